// File: rtl/dm_arbiter_pkg.sv
// Shared definitions for the data-memory path: DMType codes, arbiter FSM states
// and the request record latched at acceptance.
package dm_arbiter_pkg;

    localparam int ADDR_W = 6;
    localparam int DATA_W = 32;

    typedef enum logic [2:0] {
        dm_word              = 3'b000,
        dm_halfword          = 3'b001,
        dm_halfword_unsigned = 3'b010,
        dm_byte              = 3'b011,
        dm_byte_unsigned     = 3'b100
    } dm_type_e;

    typedef enum logic [1:0] {
        st_idle  = 2'b00,
        st_issue = 2'b01,
        st_resp  = 2'b10
    } arb_state_e;

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [2:0]        dm_type;
        logic              owner;
        logic              err;
    } arb_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter. The pointer names the preferred port and
// moves to the port that lost (or did not compete) each time a grant is taken.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    logic ptr_q, ptr_d;

    // NOTE: default assignment at the top of every always_comb keeps it latch-free.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance && (|grant)) begin
            ptr_d = grant[0];
        end
    end

    // NOTE: flops use non-blocking assignment so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

// File: rtl/dm_arbiter.sv
// Shares the single data-memory port between the CPU LSU (port 0) and a debug/DMA
// requester (port 1), one transaction at a time through IDLE -> ISSUE -> RESP.
module dm_arbiter
    import dm_arbiter_pkg::*;
#(
    parameter int NPORT = 2
) (
    input  logic              Clk_CPU,
    input  logic              rstn,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic [2:0]        req0_type,
    output logic              resp0_valid,
    output logic [DATA_W-1:0] resp0_rdata,
    output logic              resp0_err,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    input  logic [2:0]        req1_type,
    output logic              resp1_valid,
    output logic [DATA_W-1:0] resp1_rdata,
    output logic              resp1_err,
    output logic              dm_wr,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [DATA_W-1:0] dm_din,
    output logic [2:0]        dm_type,
    input  logic [DATA_W-1:0] dm_dout
);

    arb_state_e        state_q, state_d;
    arb_req_t          req_q, req_d;
    logic [NPORT-1:0]  valid_vec, grant_vec;
    logic              handshake;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [2:0]        sel_type;
    logic [DATA_W-1:0] load_data;

    // Reserved type codes and misaligned halfword/word accesses never reach dm.
    function automatic logic access_err(input logic [2:0] t, input logic [ADDR_W-1:0] a);
        logic err;
        case (t)
            dm_word:                           err = (a[1:0] != 2'b00);
            dm_halfword, dm_halfword_unsigned: err = a[0];
            dm_byte, dm_byte_unsigned:         err = 1'b0;
            default:                           err = 1'b1;
        endcase
        return err;
    endfunction

    assign valid_vec = {req1_valid, req0_valid};
    assign handshake = (state_q == st_idle) && (|grant_vec);

    assign sel_we    = grant_vec[1] ? req1_we    : req0_we;
    assign sel_addr  = grant_vec[1] ? req1_addr  : req0_addr;
    assign sel_wdata = grant_vec[1] ? req1_wdata : req0_wdata;
    assign sel_type  = grant_vec[1] ? req1_type  : req0_type;

    rr_arb2 u_rr_arb2 (
        .clk     (Clk_CPU),
        .rst_n   (rstn),
        .req     (valid_vec),
        .advance (handshake),
        .grant   (grant_vec)
    );

    always_ff @(posedge Clk_CPU or negedge rstn) begin
        if (!rstn) begin
            state_q <= st_idle;
            req_q   <= '{we: 1'b0, addr: '0, wdata: '0, dm_type: dm_word, owner: 1'b0, err: 1'b0};
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
        end
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        unique case (state_q)
            st_idle: begin
                if (handshake) begin
                    state_d = st_issue;
                    req_d   = '{we: sel_we, addr: sel_addr, wdata: sel_wdata, dm_type: sel_type,
                                owner: grant_vec[1], err: access_err(sel_type, sel_addr)};
                end
            end
            st_issue: state_d = st_resp;
            st_resp:  state_d = st_idle;
            default:  state_d = st_idle;
        endcase
    end

    // The dm address/data/type always come from the latched request so the read
    // mux in dm never sees a glitch; only the write strobe is gated by state.
    always_comb begin
        req0_ready  = (state_q == st_idle) && grant_vec[0];
        req1_ready  = (state_q == st_idle) && grant_vec[1];
        dm_wr       = (state_q == st_issue) && req_q.we && !req_q.err;
        dm_addr     = req_q.addr;
        dm_din      = req_q.wdata;
        dm_type     = req_q.dm_type;
        load_data   = (!req_q.we && !req_q.err) ? dm_dout : '0;
        resp0_valid = (state_q == st_resp) && !req_q.owner;
        resp1_valid = (state_q == st_resp) && req_q.owner;
        resp0_rdata = resp0_valid ? load_data : '0;
        resp1_rdata = resp1_valid ? load_data : '0;
        resp0_err   = resp0_valid && req_q.err;
        resp1_err   = resp1_valid && req_q.err;
    end

endmodule

// File: tb/tb_dm_arbiter.sv
// Scoreboard bench for dm_arbiter with a behavioural byte-addressed dm behind it
// (byte i initialised to i) and an independent reference memory for expectations.
module tb_dm_arbiter;

    typedef struct {
        int          port;
        logic [31:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk;
    logic        rstn;
    logic        v     [2];
    logic        we    [2];
    logic [5:0]  addr  [2];
    logic [31:0] wdata [2];
    logic [2:0]  typ   [2];
    logic        rdy   [2];
    logic        rv    [2];
    logic        rerr  [2];
    logic [31:0] rdata [2];
    logic        dm_wr;
    logic [5:0]  dm_addr;
    logic [31:0] dm_din;
    logic [2:0]  dm_type;
    logic [31:0] dm_dout;

    logic [7:0]  dm_mem  [64];
    logic [7:0]  ref_mem [64];
    bit          mem_init;
    int          cyc;
    int          n_vec;
    int          n_err;
    exp_t        sb_q    [$];
    int          grant_q [$];

    dm_arbiter #(.NPORT(2)) dut (
        .Clk_CPU     (clk),
        .rstn        (rstn),
        .req0_valid  (v[0]),
        .req0_ready  (rdy[0]),
        .req0_we     (we[0]),
        .req0_addr   (addr[0]),
        .req0_wdata  (wdata[0]),
        .req0_type   (typ[0]),
        .resp0_valid (rv[0]),
        .resp0_rdata (rdata[0]),
        .resp0_err   (rerr[0]),
        .req1_valid  (v[1]),
        .req1_ready  (rdy[1]),
        .req1_we     (we[1]),
        .req1_addr   (addr[1]),
        .req1_wdata  (wdata[1]),
        .req1_type   (typ[1]),
        .resp1_valid (rv[1]),
        .resp1_rdata (rdata[1]),
        .resp1_err   (rerr[1]),
        .dm_wr       (dm_wr),
        .dm_addr     (dm_addr),
        .dm_din      (dm_din),
        .dm_type     (dm_type),
        .dm_dout     (dm_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] extend(input logic [31:0] raw, input logic [2:0] t);
        case (t)
            3'd0:    return raw;
            3'd1:    return {{16{raw[15]}}, raw[15:0]};
            3'd2:    return {16'h0, raw[15:0]};
            3'd3:    return {{24{raw[7]}}, raw[7:0]};
            3'd4:    return {24'h0, raw[7:0]};
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_err(input logic [2:0] t, input logic [5:0] a);
        if (t > 3'd4) return 1'b1;
        if ((t == 3'd1 || t == 3'd2) && a[0]) return 1'b1;
        if (t == 3'd0 && a[1:0] != 2'b00) return 1'b1;
        return 1'b0;
    endfunction

    // Behavioural dm: writes and refreshes dout on every rising edge.
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < 64; i++) dm_mem[i] <= 8'(i);
            mem_init <= 1'b1;
        end else if (dm_wr) begin
            dm_mem[dm_addr] <= dm_din[7:0];
            if (dm_type == 3'd0 || dm_type == 3'd1 || dm_type == 3'd2)
                dm_mem[6'(dm_addr + 6'd1)] <= dm_din[15:8];
            if (dm_type == 3'd0) begin
                dm_mem[6'(dm_addr + 6'd2)] <= dm_din[23:16];
                dm_mem[6'(dm_addr + 6'd3)] <= dm_din[31:24];
            end
        end
        dm_dout <= extend({dm_mem[6'(dm_addr + 6'd3)], dm_mem[6'(dm_addr + 6'd2)],
                           dm_mem[6'(dm_addr + 6'd1)], dm_mem[dm_addr]}, dm_type);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [5:0] a, input logic [2:0] t);
        return extend({ref_mem[6'(a + 6'd3)], ref_mem[6'(a + 6'd2)],
                       ref_mem[6'(a + 6'd1)], ref_mem[a]}, t);
    endfunction

    task automatic ref_store(input logic [5:0] a, input logic [31:0] d, input logic [2:0] t);
        int n;
        n = (t == 3'd0) ? 4 : ((t == 3'd1 || t == 3'd2) ? 2 : 1);
        for (int k = 0; k < n; k++) ref_mem[6'(a + 6'(k))] = d[8*k +: 8];
    endtask

    // One request from port p; keep leaves valid high for a follow-on request,
    // abort pulls reset during the ISSUE cycle and expects no response.
    task automatic send(input int p, input logic w, input logic [5:0] a, input logic [31:0] d,
                        input logic [2:0] t, input bit keep, input bit abort);
        bit   got;
        logic e_err;
        exp_t e;
        got = 1'b0;
        @(negedge clk);
        v[p] = 1'b1; we[p] = w; addr[p] = a; wdata[p] = d; typ[p] = t;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (rdy[p]) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("handshake_seen", {31'h0, got}, 32'h1);
        if (!got) begin
            v[p] = 1'b0;
            return;
        end
        e_err = ref_err(t, a);
        grant_q.push_back(p);
        if (!abort) begin
            e.port  = p;
            e.err   = e_err;
            e.rdata = (w || e_err) ? 32'h0 : ref_load(a, t);
            e.cyc   = cyc + 2;
            sb_q.push_back(e);
            if (w && !e_err) ref_store(a, d, t);
        end
        @(posedge clk);
        #1;
        if (!keep) v[p] = 1'b0;
        @(negedge clk);
        if (abort) begin
            rstn = 1'b0;
            #1;
            check("abort_dm_wr", {31'h0, dm_wr}, 32'h0);
            @(negedge clk);
            rstn = 1'b1;
        end else begin
            check("issue_dm_wr",   {31'h0, dm_wr}, {31'h0, w && !e_err});
            check("issue_dm_addr", {26'h0, dm_addr}, {26'h0, a});
            check("issue_dm_type", {29'h0, dm_type}, {29'h0, t});
            check("issue_dm_din",  dm_din, d);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", sb_q.size(), 32'h0);
    endtask

    // Response monitor: pops the scoreboard whenever any port completes.
    initial begin
        exp_t e;
        int   p;
        forever begin
            @(negedge clk);
            #2;
            check("ready_exclusive", {31'h0, rdy[0] & rdy[1]}, 32'h0);
            if (rv[0] || rv[1]) begin
                check("resp_exclusive", {31'h0, rv[0] & rv[1]}, 32'h0);
                if (sb_q.size() == 0) begin
                    check("resp_unexpected", {31'h0, rv[0] | rv[1]}, 32'h0);
                end else begin
                    e = sb_q.pop_front();
                    p = rv[1] ? 1 : 0;
                    check("resp_port",  p, e.port);
                    check("resp_rdata", rdata[p], e.rdata);
                    check("resp_err",   {31'h0, rerr[p]}, {31'h0, e.err});
                    check("resp_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'(i);
        for (int i = 0; i < 2; i++) begin
            v[i] = 1'b0; we[i] = 1'b0; addr[i] = '0; wdata[i] = '0; typ[i] = '0;
        end
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready0",  {31'h0, rdy[0]}, 32'h0);
        check("rst_ready1",  {31'h0, rdy[1]}, 32'h0);
        check("rst_rvalid0", {31'h0, rv[0]}, 32'h0);
        check("rst_rvalid1", {31'h0, rv[1]}, 32'h0);
        check("rst_rerr0",   {31'h0, rerr[0]}, 32'h0);
        check("rst_rerr1",   {31'h0, rerr[1]}, 32'h0);
        check("rst_rdata0",  rdata[0], 32'h0);
        check("rst_rdata1",  rdata[1], 32'h0);
        check("rst_dm_wr",   {31'h0, dm_wr}, 32'h0);
        check("rst_dm_din",  dm_din, 32'h0);
        check("rst_dm_addr", {26'h0, dm_addr}, 32'h0);
        check("rst_dm_type", {29'h0, dm_type}, 32'h0);
        @(negedge clk);
        rstn = 1'b1;

        send(0, 1'b0, 6'd4,    32'h0,        3'd0, 1'b0, 1'b0);
        send(1, 1'b1, 6'd9,    32'h80,       3'd3, 1'b0, 1'b0);
        send(1, 1'b0, 6'd9,    32'h0,        3'd3, 1'b0, 1'b0);
        send(1, 1'b0, 6'd9,    32'h0,        3'd4, 1'b0, 1'b0);
        send(0, 1'b1, 6'd3,    32'h1111,     3'd1, 1'b0, 1'b0);
        send(0, 1'b1, 6'd6,    32'h22222222, 3'd0, 1'b0, 1'b0);
        send(0, 1'b0, 6'd4,    32'h0,        3'd0, 1'b0, 1'b0);
        send(1, 1'b0, 6'd12,   32'h0,        3'd7, 1'b0, 1'b0);
        send(1, 1'b0, 6'd12,   32'h0,        3'd5, 1'b0, 1'b0);
        send(0, 1'b1, 6'h30,   32'hCAFEF00D, 3'd0, 1'b0, 1'b0);
        send(1, 1'b0, 6'h30,   32'h0,        3'd0, 1'b0, 1'b0);
        send(1, 1'b0, 6'h32,   32'h0,        3'd1, 1'b0, 1'b0);
        send(0, 1'b0, 6'h30,   32'h0,        3'd2, 1'b0, 1'b0);
        send(1, 1'b0, 6'h31,   32'h0,        3'd2, 1'b0, 1'b0);
        drain();

        send(0, 1'b1, 6'd8, 32'hDEADBEEF, 3'd0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            check("abort_no_resp", {30'h0, rv[1], rv[0]}, 32'h0);
        end
        send(0, 1'b0, 6'd8, 32'h0, 3'd0, 1'b0, 1'b0);
        drain();

        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        grant_q.delete();
        fork
            begin
                send(0, 1'b0, 6'h10, 32'h0, 3'd0, 1'b1, 1'b0);
                send(0, 1'b0, 6'h14, 32'h0, 3'd0, 1'b0, 1'b0);
            end
            begin
                send(1, 1'b0, 6'h20, 32'h0, 3'd0, 1'b1, 1'b0);
                send(1, 1'b0, 6'h24, 32'h0, 3'd0, 1'b0, 1'b0);
            end
        join
        drain();
        check("grant_count", grant_q.size(), 32'd4);
        for (int i = 0; i < grant_q.size() && i < 4; i++) begin
            check($sformatf("grant_order_%0d", i), grant_q[i], i % 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
